// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc writeback stage: register addresses,
// load-type encodings (RV32I funct3) and the writeback data source select.
package jzjpcc_pkg;

   localparam int XLEN = 32;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic {
      ALU = 1'b0,
      MEM = 1'b1
   } rd_source_t;

   // Sign- or zero-extend an 8-bit value to XLEN
   function automatic logic [XLEN-1:0] extend8(input logic [7:0] val, input logic is_signed);
      return {{(XLEN-8){is_signed & val[7]}}, val};
   endfunction

   // Sign- or zero-extend a 16-bit value to XLEN
   function automatic logic [XLEN-1:0] extend16(input logic [15:0] val, input logic is_signed);
      return {{(XLEN-16){is_signed & val[15]}}, val};
   endfunction

endpackage

// File: rtl/jzjpcc_regfile.sv
// 31x32 integer register file, one write port and two combinational read
// ports. x0 has no storage and always reads zero. Optional write-through
// bypass lets a read see the value being written in the same cycle.
module jzjpcc_regfile
   import jzjpcc_pkg::*;
#(
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic              i_clock,
   input  logic              i_wr_en,
   input  reg_addr_t         i_wr_addr,
   input  logic [XLEN-1:0]   i_wr_data,
   input  reg_addr_t         i_rd1_addr,
   input  reg_addr_t         i_rd2_addr,
   output logic [XLEN-1:0]   o_rd1_data,
   output logic [XLEN-1:0]   o_rd2_data
);

   // Storage for x1..x31 only; contents are intentionally not reset.
   logic [XLEN-1:0] r_regs [1:31];

   reg_addr_t w_rd_addr [2];

   assign w_rd_addr[0] = i_rd1_addr;
   assign w_rd_addr[1] = i_rd2_addr;

   // Commit the write; x0 writes are dropped because x0 has no storage
   always_ff @(posedge i_clock) begin
      if (i_wr_en && (i_wr_addr != '0)) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   // Identical read logic for both ports: x0 -> 0, then bypass, then storage
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic w_hit;
         logic [XLEN-1:0] w_data;

         assign w_hit  = BYPASS_EN && i_wr_en && (i_wr_addr != '0) && (w_rd_addr[gi] == i_wr_addr);
         assign w_data = (w_rd_addr[gi] == '0) ? '0 :
                         w_hit                 ? i_wr_data :
                                                 r_regs[w_rd_addr[gi]];
      end
   endgenerate

   assign o_rd1_data = g_rd[0].w_data;
   assign o_rd2_data = g_rd[1].w_data;

endmodule

// File: rtl/jzjpcc_writeback.sv
// Final pipeline stage: formats load data, selects the value written back,
// owns the register file, exposes a forwarding tap to execute and counts
// retired instructions.
module jzjpcc_writeback
   import jzjpcc_pkg::*;
#(
   parameter int INSTRET_WIDTH = 64,
   parameter bit BYPASS_EN     = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [4:0]               rdAddr_writeback,
   input  logic                     rdWriteEnable_writeback,
   input  logic                     rdSource_writeback,
   input  logic [31:0]              memoryOut_writeback,
   input  logic [31:0]              aluResult_writeback,
   input  logic [2:0]               funct3_writeback,
   input  logic [1:0]               byteOffset_writeback,
   input  logic                     retire_writeback,
   input  logic [4:0]               rs1Addr_decode,
   input  logic [4:0]               rs2Addr_decode,
   output logic [31:0]              rs1Data_decode,
   output logic [31:0]              rs2Data_decode,
   output logic [4:0]               fwdAddr_execute,
   output logic                     fwdValid_execute,
   output logic [31:0]              fwdData_execute,
   output logic [INSTRET_WIDTH-1:0] instretCount
);

   logic [7:0]               w_byte;
   logic [15:0]              w_half;
   logic [31:0]              w_load_data;
   logic [31:0]              w_wdata;
   logic                     w_write_qual;
   logic [INSTRET_WIDTH-1:0] r_instret;

   // Half-word select uses only offset bit 1; misaligned halves never get here.
   assign w_byte = memoryOut_writeback[{byteOffset_writeback, 3'b000} +: 8];
   assign w_half = memoryOut_writeback[{byteOffset_writeback[1], 4'b0000} +: 16];

   // Extract and extend the addressed byte/half according to the load type
   always_comb begin
      w_load_data = memoryOut_writeback;
      case (load_funct3_t'(funct3_writeback))
         LB:      w_load_data = extend8(w_byte, 1'b1);
         LBU:     w_load_data = extend8(w_byte, 1'b0);
         LH:      w_load_data = extend16(w_half, 1'b1);
         LHU:     w_load_data = extend16(w_half, 1'b0);
         default: w_load_data = memoryOut_writeback;
      endcase
   end

   assign w_wdata = (rd_source_t'(rdSource_writeback) == MEM) ? w_load_data : aluResult_writeback;

   // A write only counts when out of reset and not targeting x0.
   assign w_write_qual = reset & rdWriteEnable_writeback & (rdAddr_writeback != 5'd0);

   jzjpcc_regfile #(
      .BYPASS_EN (BYPASS_EN)
   ) u_regfile (
      .i_clock    (clock),
      .i_wr_en    (w_write_qual),
      .i_wr_addr  (rdAddr_writeback),
      .i_wr_data  (w_wdata),
      .i_rd1_addr (rs1Addr_decode),
      .i_rd2_addr (rs2Addr_decode),
      .o_rd1_data (rs1Data_decode),
      .o_rd2_data (rs2Data_decode)
   );

   assign fwdAddr_execute  = rdAddr_writeback;
   assign fwdData_execute  = w_wdata;
   assign fwdValid_execute = w_write_qual;

   // Retired-instruction counter; cleared in reset, wraps naturally at all-ones
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_instret <= '0;
      end else if (retire_writeback) begin
         r_instret <= r_instret + INSTRET_WIDTH'(1);
      end
   end

   assign instretCount = r_instret;

endmodule

// File: tb/tb_jzjpcc_writeback.sv
// Scoreboard bench for jzjpcc_writeback: a driver issues one transaction per
// cycle and queues the expected outputs from a behavioural model; a monitor
// pops and compares on the falling edge. A second instance with bypass
// disabled shares all inputs.
module tb_jzjpcc_writeback;

   localparam int IW = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [4:0]    rdAddr_writeback = '0;
   logic          rdWriteEnable_writeback = 1'b0;
   logic          rdSource_writeback = 1'b0;
   logic [31:0]   memoryOut_writeback = '0;
   logic [31:0]   aluResult_writeback = '0;
   logic [2:0]    funct3_writeback = '0;
   logic [1:0]    byteOffset_writeback = '0;
   logic          retire_writeback = 1'b0;
   logic [4:0]    rs1Addr_decode = '0;
   logic [4:0]    rs2Addr_decode = '0;

   logic [31:0]   rs1Data_decode, rs2Data_decode;
   logic [4:0]    fwdAddr_execute;
   logic          fwdValid_execute;
   logic [31:0]   fwdData_execute;
   logic [IW-1:0] instretCount;

   logic [31:0]   nb_rs1, nb_rs2, nb_fwd_data;
   logic [4:0]    nb_fwd_addr;
   logic          nb_fwd_valid;
   logic [IW-1:0] nb_instret;

   always #5 clock = ~clock;

   jzjpcc_writeback #(.INSTRET_WIDTH(IW), .BYPASS_EN(1'b1)) dut (
      .clock(clock), .reset(reset),
      .rdAddr_writeback(rdAddr_writeback), .rdWriteEnable_writeback(rdWriteEnable_writeback),
      .rdSource_writeback(rdSource_writeback), .memoryOut_writeback(memoryOut_writeback),
      .aluResult_writeback(aluResult_writeback), .funct3_writeback(funct3_writeback),
      .byteOffset_writeback(byteOffset_writeback), .retire_writeback(retire_writeback),
      .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
      .rs1Data_decode(rs1Data_decode), .rs2Data_decode(rs2Data_decode),
      .fwdAddr_execute(fwdAddr_execute), .fwdValid_execute(fwdValid_execute),
      .fwdData_execute(fwdData_execute), .instretCount(instretCount)
   );

   jzjpcc_writeback #(.INSTRET_WIDTH(IW), .BYPASS_EN(1'b0)) dut_nb (
      .clock(clock), .reset(reset),
      .rdAddr_writeback(rdAddr_writeback), .rdWriteEnable_writeback(rdWriteEnable_writeback),
      .rdSource_writeback(rdSource_writeback), .memoryOut_writeback(memoryOut_writeback),
      .aluResult_writeback(aluResult_writeback), .funct3_writeback(funct3_writeback),
      .byteOffset_writeback(byteOffset_writeback), .retire_writeback(retire_writeback),
      .rs1Addr_decode(rs1Addr_decode), .rs2Addr_decode(rs2Addr_decode),
      .rs1Data_decode(nb_rs1), .rs2Data_decode(nb_rs2),
      .fwdAddr_execute(nb_fwd_addr), .fwdValid_execute(nb_fwd_valid),
      .fwdData_execute(nb_fwd_data), .instretCount(nb_instret)
   );

   typedef struct {
      int            id;
      bit            c1, c2, cn1, cn2, ccnt;
      logic [31:0]   r1, r2, n1, n2;
      bit            fv;
      logic [4:0]    fa;
      logic [31:0]   fd;
      logic [IW-1:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          txn     = 0;

   // Reference state: architectural registers, which are known, and the counter
   logic [31:0] m_regs  [32];
   bit          m_known [32];
   int unsigned m_cnt   = 0;
   bit          m_cnt_known = 1'b0;

   // RV32I load semantics with plain arithmetic on the raw word
   function automatic logic [31:0] ref_load(input logic [31:0] m, input logic [2:0] f, input logic [1:0] o);
      int unsigned b, h;
      b = (m >> (8 * int'(o))) % 256;
      h = (m >> (16 * (int'(o) / 2))) % 65536;
      case (f)
         3'd0:    return (b >= 128)   ? 32'(b) - 32'd256   : 32'(b);
         3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
         3'd4:    return 32'(b);
         3'd5:    return 32'(h);
         default: return m;
      endcase
   endfunction

   // Expected value of one read port, with and without bypass
   task automatic exp_port(input logic [4:0] p, input bit qual, input logic [4:0] rd, input logic [31:0] wd,
                           output bit c, output logic [31:0] v, output bit cn, output logic [31:0] vn);
      if (p == 5'd0) begin
         c = 1'b1; v = '0; cn = 1'b1; vn = '0;
      end else begin
         cn = m_known[p]; vn = m_regs[p];
         if (qual && (p == rd)) begin c = 1'b1; v = wd; end
         else begin c = m_known[p]; v = m_regs[p]; end
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then advance the model
   task automatic cyc(input bit rst_n, input bit w, input logic [4:0] rd, input bit s,
                      input logic [31:0] m, input logic [31:0] a, input logic [2:0] f,
                      input logic [1:0] o, input bit r, input logic [4:0] p1, input logic [4:0] p2);
      exp_t        e;
      logic [31:0] wd;
      bit          qual;
      @(posedge clock);
      #1;
      reset = rst_n; rdWriteEnable_writeback = w; rdAddr_writeback = rd; rdSource_writeback = s;
      memoryOut_writeback = m; aluResult_writeback = a; funct3_writeback = f;
      byteOffset_writeback = o; retire_writeback = r; rs1Addr_decode = p1; rs2Addr_decode = p2;
      wd   = s ? ref_load(m, f, o) : a;
      qual = rst_n && w && (rd != 5'd0);
      e.id = txn;
      txn++;
      exp_port(p1, qual, rd, wd, e.c1, e.r1, e.cn1, e.n1);
      exp_port(p2, qual, rd, wd, e.c2, e.r2, e.cn2, e.n2);
      e.fv   = qual;
      e.fa   = rd;
      e.fd   = wd;
      e.ccnt = m_cnt_known;
      e.cnt  = IW'(m_cnt);
      q.push_back(e);
      if (qual) begin
         m_regs[rd]  = wd;
         m_known[rd] = 1'b1;
      end
      if (!rst_n) begin
         m_cnt = 0; m_cnt_known = 1'b1;
      end else if (r) begin
         m_cnt = (m_cnt + 1) % (1 << IW);
      end
   endtask

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s txn %0d: got %08h expected %08h", nm, id, act, exp);
      end
   endtask

   // Monitor: compare the presented outputs against the oldest expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c1)   chk("rs1", e.id, rs1Data_decode, e.r1);
            if (e.c2)   chk("rs2", e.id, rs2Data_decode, e.r2);
            if (e.cn1)  chk("rs1_nobypass", e.id, nb_rs1, e.n1);
            if (e.cn2)  chk("rs2_nobypass", e.id, nb_rs2, e.n2);
            chk("fwdValid", e.id, 32'(fwdValid_execute), 32'(e.fv));
            chk("fwdAddr",  e.id, 32'(fwdAddr_execute),  32'(e.fa));
            chk("fwdData",  e.id, fwdData_execute, e.fd);
            if (e.ccnt) chk("instret", e.id, 32'(instretCount), 32'(e.cnt));
            $display("[TB] txn %0d rs1=%08h rs2=%08h fwd=%0d/%0d/%08h instret=%0d",
                     e.id, rs1Data_decode, rs2Data_decode, fwdValid_execute,
                     fwdAddr_execute, fwdData_execute, instretCount);
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0; m_known[i] = (i == 0);
      end

      // Initial reset, then give every register a known value
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i < 32; i++)
         cyc(1, 1, 5'(i), 0, 0, $urandom, 0, 0, 1, 5'(i), 0);

      // Reset held two cycles with retire and a write to x5: nothing sticks
      cyc(0, 1, 5, 0, 0, 32'hAAAA5555, 0, 0, 1, 5, 0);
      cyc(0, 1, 5, 0, 0, 32'h5555AAAA, 0, 0, 1, 5, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);

      // ALU write then read back next cycle
      cyc(1, 1, 3, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);

      // Load formatting cases on a fixed memory word
      cyc(1, 1, 10, 1, 32'h80FF7F01, $urandom, 3'b000, 2'd0, 1, 10, 0);
      cyc(1, 1, 11, 1, 32'h80FF7F01, $urandom, 3'b000, 2'd2, 1, 11, 0);
      cyc(1, 1, 12, 1, 32'h80FF7F01, $urandom, 3'b100, 2'd3, 1, 12, 0);
      cyc(1, 1, 13, 1, 32'h80FF7F01, $urandom, 3'b001, 2'd2, 1, 13, 0);
      cyc(1, 1, 14, 1, 32'h80FF7F01, $urandom, 3'b101, 2'd0, 1, 14, 0);
      cyc(1, 1, 15, 1, 32'h80FF7F01, $urandom, 3'b010, 2'd1, 1, 15, 0);

      // Same-cycle write and read of x7 on both ports
      cyc(1, 1, 7, 0, 0, 32'h12345678, 0, 0, 0, 7, 7);

      // Write to x0 is dropped; then sweep every register to confirm nothing moved
      cyc(1, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i += 2)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 1));

      // Counter: clear, count to all-ones, one more wraps to zero
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < (1 << IW); i++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         cyc(($urandom_range(0, 19) != 0), 1'($urandom), 5'($urandom), 1'($urandom), $urandom,
             $urandom, 3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
      end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

      // Bounded drain of the scoreboard
      for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clock);
      n_tests++;
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
